// File: rtl/gates_bist_pkg.sv
// Shared types and golden truth table for the two-input gate bank self-test.
package gates_bist_pkg;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} bist_state_t;

  localparam int unsigned GATE_OUTS = 8;

  localparam int unsigned BIT_AND  = 0;
  localparam int unsigned BIT_OR   = 1;
  localparam int unsigned BIT_NOTA = 2;
  localparam int unsigned BIT_NOTB = 3;
  localparam int unsigned BIT_XOR  = 4;
  localparam int unsigned BIT_NAND = 5;
  localparam int unsigned BIT_NOR  = 6;
  localparam int unsigned BIT_XNOR = 7;

  function automatic logic [GATE_OUTS-1:0] golden_rsp(input logic a, input logic b);
    logic [GATE_OUTS-1:0] g;
    g           = '0;
    g[BIT_AND]  = a & b;
    g[BIT_OR]   = a | b;
    g[BIT_NOTA] = ~a;
    g[BIT_NOTB] = ~b;
    g[BIT_XOR]  = a ^ b;
    g[BIT_NAND] = ~(a & b);
    g[BIT_NOR]  = ~(a | b);
    g[BIT_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gates_bist_scoreboard.sv
// Response checker: mismatch against golden, sticky fail mask, saturating
// error count and capture of the first failing vector.
module gates_bist_scoreboard
  import gates_bist_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 chk_en_i,
  input  logic [1:0]           vec_i,
  input  logic [GATE_OUTS-1:0] rsp_i,
  output logic [GATE_OUTS-1:0] fail_mask_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [1:0]           first_fail_vec_o
);

  logic [GATE_OUTS-1:0] mism;
  logic [GATE_OUTS-1:0] fail_mask_q, fail_mask_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [1:0]           ffv_q, ffv_d;

  assign mism = rsp_i ^ golden_rsp(vec_i[1], vec_i[0]);

  always_comb begin
    fail_mask_d = fail_mask_q;
    err_cnt_d   = err_cnt_q;
    ffv_d       = ffv_q;
    if (clr_i) begin
      fail_mask_d = '0;
      err_cnt_d   = '0;
      ffv_d       = '0;
    end else if (chk_en_i) begin
      fail_mask_d = fail_mask_q | mism;
      if (mism != '0) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        // Only the very first failing vector of a run is recorded.
        if (err_cnt_q == '0) ffv_d = vec_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_mask_q <= '0;
      err_cnt_q   <= '0;
      ffv_q       <= '0;
    end else begin
      fail_mask_q <= fail_mask_d;
      err_cnt_q   <= err_cnt_d;
      ffv_q       <= ffv_d;
    end
  end

  assign fail_mask_o      = fail_mask_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_fail_vec_o = ffv_q;

endmodule

// File: rtl/gates_bist_checker.sv
// BIST sequencer for the gate bank: sweeps the four a/b vectors NUM_PASSES
// times, settles, checks each response and reports pass/fail.
module gates_bist_checker
  import gates_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned NUM_PASSES    = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [GATE_OUTS-1:0] rsp,
  output logic                 drv_a,
  output logic                 drv_b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [GATE_OUTS-1:0] fail_mask,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [1:0]           first_fail_vec
);

  localparam int unsigned       PASS_W      = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(NUM_PASSES - 1);
  localparam logic [3:0]        SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  bist_state_t       state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [PASS_W-1:0] pcnt_q, pcnt_d;
  logic [3:0]        scnt_q, scnt_d;
  logic [1:0]        drv_q, drv_d;
  logic              pass_q, pass_d;
  logic              clr, chk_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    scnt_d  = scnt_q;
    drv_d   = drv_q;
    pass_d  = pass_q;
    clr     = 1'b0;
    chk_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          clr     = 1'b1;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          pcnt_d  = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        drv_d   = idx_q;
        scnt_d  = SETTLE_LOAD;
        state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (scnt_q == 4'd0) state_d = CHECK;
        else                scnt_d  = scnt_q - 4'd1;
      end
      CHECK: begin
        chk_en = 1'b1;
        if (idx_q == 2'd3 && pcnt_q == LAST_PASS) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) pcnt_d = pcnt_q + PASS_W'(1);
          state_d = DRIVE;
        end
      end
      DONE: begin
        pass_d  = (err_cnt == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort beats everything; scoreboard contents are left as they stand.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      drv_d   = 2'b00;
      pass_d  = 1'b0;
      chk_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
      drv_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
      drv_q   <= drv_d;
      pass_q  <= pass_d;
    end
  end

  gates_bist_scoreboard #(.CNT_W(CNT_W)) u_sb (
    .clk              (clk),
    .rst_n            (rst_n),
    .clr_i            (clr),
    .chk_en_i         (chk_en),
    .vec_i            (drv_q),
    .rsp_i            (rsp),
    .fail_mask_o      (fail_mask),
    .err_cnt_o        (err_cnt),
    .first_fail_vec_o (first_fail_vec)
  );

  assign drv_a = drv_q[1];
  assign drv_b = drv_q[0];
  assign busy  = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  // pass already reflects the run during the DONE cycle itself.
  assign done  = (state_q == DONE) && !abort;
  assign pass  = (state_q == DONE) ? ((err_cnt == '0) && !abort) : pass_q;

endmodule
